te_block_serializer: RTL and testbench

Sits directly downstream of the multiple-retirement stage and upstream of the trace encoder. It accepts up to N parallel trace blocks per cycle, buffers them in a circular queue, and emits them one per cycle in lane order over a valid/ready handshake. On overflow it drops whole groups, drains, and tags the next emitted block so the encoder can force a resynchronisation packet.

---
 rtl/mure_pkg.sv | 21 ++
 rtl/te_block_serializer_if.sv | 52 +++++
 rtl/te_block_serializer.sv | 178 +++++++++++++++++
 tb/tb_te_block_serializer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mure_pkg.sv
// Shared field widths and the buffered trace-block record for the multiple-retirement trace path.
package mure_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned IRETIRE_LEN = 8;
    localparam int unsigned ITYPE_LEN   = 4;
    localparam int unsigned CAUSE_LEN   = 5;
    localparam int unsigned PRIV_LEN    = 2;

    typedef struct packed {
        logic                   resync;
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
        logic [XLEN-1:0]        iaddr;
    } te_block_t;

endpackage

// File: rtl/te_block_serializer_if.sv
// Parallel block group in, serialized block stream out for te_block_serializer.
// Optional dropped_o appears when TE_SERIALIZER_DROP_CNT_EN is defined.
interface te_block_serializer_if #(
    parameter int unsigned N     = 1,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [N-1:0]                                valid_i;
    logic [N-1:0][mure_pkg::IRETIRE_LEN-1:0]     iretire_i;
    logic [N-1:0]                                ilastsize_i;
    logic [N-1:0][mure_pkg::ITYPE_LEN-1:0]       itype_i;
    logic [mure_pkg::CAUSE_LEN-1:0]              cause_i;
    logic [mure_pkg::XLEN-1:0]                   tval_i;
    logic [mure_pkg::PRIV_LEN-1:0]               priv_i;
    logic [N-1:0][mure_pkg::XLEN-1:0]            iaddr_i;
    logic                                        ready_i;

    logic                                        valid_o;
    logic [mure_pkg::IRETIRE_LEN-1:0]            iretire_o;
    logic                                        ilastsize_o;
    logic [mure_pkg::ITYPE_LEN-1:0]              itype_o;
    logic [mure_pkg::CAUSE_LEN-1:0]              cause_o;
    logic [mure_pkg::XLEN-1:0]                   tval_o;
    logic [mure_pkg::PRIV_LEN-1:0]               priv_o;
    logic [mure_pkg::XLEN-1:0]                   iaddr_o;
    logic                                        resync_o;
    logic                                        overflow_o;
    logic [CW-1:0]                               usage_o;
`ifdef TE_SERIALIZER_DROP_CNT_EN
    logic [15:0]                                 dropped_o;
`endif

    modport slave (
        input  valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
        output valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
               resync_o, overflow_o, usage_o
`ifdef TE_SERIALIZER_DROP_CNT_EN
        , output dropped_o
`endif
    );

    modport master (
        output valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
        input  valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
               resync_o, overflow_o, usage_o
`ifdef TE_SERIALIZER_DROP_CNT_EN
        , input dropped_o
`endif
    );

endinterface

// File: rtl/te_block_serializer.sv
// Buffers up to N trace blocks per cycle and emits them one per cycle in lane order; on overflow
// drops whole groups, drains, and tags the next block for resync. TE_SERIALIZER_DROP_CNT_EN adds dropped_o.
module te_block_serializer
    import mure_pkg::*;
#(
    parameter int unsigned N     = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    te_block_serializer_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_RESYNC} state_e;

    state_e          state_q, state_nxt;
    logic [AW-1:0]   wptr_q, wptr_nxt;
    logic [AW-1:0]   rptr_q, rptr_nxt;
    logic [CW-1:0]   count_q, count_nxt;
    logic            valid_q;
    logic            overflow_q;
    te_block_t       head_q, head_nxt;
    te_block_t       mem_q   [DEPTH];
    te_block_t       mem_nxt [DEPTH];
    te_block_t       lane_ent [N];

    logic [CW-1:0]   k;
    logic            fits;
    logic            pop;
    logic            accept;
    logic            tag;
    logic            set_ovf;

    // Group size and space check against pre-pop occupancy
    always_comb begin
        k = '0;
        for (int l = 0; l < N; l++) begin
            k = k + CW'(bus.valid_i[l]);
        end
    end

    assign fits = (k <= (CW'(DEPTH) - count_q));
    assign pop  = valid_q & bus.ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        tag       = 1'b0;
        set_ovf   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (k != '0) begin
                    if (fits) begin
                        accept = 1'b1;
                    end else begin
                        set_ovf   = 1'b1;
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    state_nxt = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                if (k != '0) begin
                    accept    = 1'b1;
                    tag       = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Per-lane entry; only lane 0 carries trap info, and only for exception/interrupt itypes
    always_comb begin
        for (int l = 0; l < N; l++) begin
            lane_ent[l]           = '0;
            lane_ent[l].resync    = tag && (l == 0);
            lane_ent[l].iretire   = bus.iretire_i[l];
            lane_ent[l].ilastsize = bus.ilastsize_i[l];
            lane_ent[l].itype     = bus.itype_i[l];
            lane_ent[l].priv      = bus.priv_i;
            lane_ent[l].iaddr     = bus.iaddr_i[l];
            if ((l == 0) && ((bus.itype_i[0] == ITYPE_LEN'(1)) || (bus.itype_i[0] == ITYPE_LEN'(2)))) begin
                lane_ent[l].cause = bus.cause_i;
                lane_ent[l].tval  = bus.tval_i;
            end
        end
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_nxt[e] = mem_q[e];
        end
        if (accept) begin
            for (int l = 0; l < N; l++) begin
                if (bus.valid_i[l]) begin
                    mem_nxt[wptr_q + AW'(l)] = lane_ent[l];
                end
            end
        end
    end

    assign wptr_nxt  = accept ? (wptr_q + AW'(k)) : wptr_q;
    assign rptr_nxt  = rptr_q + AW'(pop);
    assign count_nxt = count_q + (accept ? k : '0) - CW'(pop);
    // Head is looked up from the post-update buffer so outputs come straight from flops
    assign head_nxt  = (count_nxt != '0) ? mem_nxt[rptr_nxt] : '0;

    always_ff @(posedge clk_i) begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_q[e] <= mem_nxt[e];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            head_q     <= '0;
        end else begin
            wptr_q     <= wptr_nxt;
            rptr_q     <= rptr_nxt;
            count_q    <= count_nxt;
            valid_q    <= (count_nxt != '0);
            overflow_q <= overflow_q | set_ovf;
            head_q     <= head_nxt;
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.iretire_o   = head_q.iretire;
    assign bus.ilastsize_o = head_q.ilastsize;
    assign bus.itype_o     = head_q.itype;
    assign bus.cause_o     = head_q.cause;
    assign bus.tval_o      = head_q.tval;
    assign bus.priv_o      = head_q.priv;
    assign bus.iaddr_o     = head_q.iaddr;
    assign bus.resync_o    = head_q.resync;
    assign bus.overflow_o  = overflow_q;
    assign bus.usage_o     = count_q;

`ifdef TE_SERIALIZER_DROP_CNT_EN
    // Any non-empty group that is not accepted is a drop, in every state
    logic [15:0] drop_cnt_q;
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, drop_cnt_q} + 17'(k);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if ((k != '0) && !accept) begin
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign bus.dropped_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_te_block_serializer.sv
// Directed bench for te_block_serializer with N=2, DEPTH=8; drop counter checks need TE_SERIALIZER_DROP_CNT_EN.
module tb_te_block_serializer;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;

    te_block_serializer_if #(.N(2), .DEPTH(8)) bus ();

    te_block_serializer #(.N(2), .DEPTH(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_grp(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [3:0] t0, input logic [3:0] t1,
                           input logic [4:0] c, input logic [31:0] tv);
        bus.valid_i        = v;
        bus.iaddr_i[0]     = a0;
        bus.iaddr_i[1]     = a1;
        bus.itype_i[0]     = t0;
        bus.itype_i[1]     = t1;
        bus.cause_i        = c;
        bus.tval_i         = tv;
        bus.iretire_i[0]   = 8'd3;
        bus.iretire_i[1]   = 8'd5;
        bus.ilastsize_i    = 2'b01;
        bus.priv_i         = 2'd3;
    endtask

    task automatic idle();
        set_grp(2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 5'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] exp_a;
        idle();
        bus.ready_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;

        // Reset state
        chk("rst_valid", 64'(bus.valid_o), 64'h0);
        chk("rst_usage", 64'(bus.usage_o), 64'h0);
        chk("rst_overflow", 64'(bus.overflow_o), 64'h0);
        chk("rst_iaddr", 64'(bus.iaddr_o), 64'h0);
        chk("rst_resync", 64'(bus.resync_o), 64'h0);

        // Lane ordering; lane 0 itype 0 must not capture cause/tval
        set_grp(2'b11, 32'h100, 32'h140, 4'd0, 4'd3, 5'd5, 32'h55);
        step();
        idle();
        chk("lo_valid0", 64'(bus.valid_o), 64'h1);
        chk("lo_iaddr0", 64'(bus.iaddr_o), 64'h100);
        chk("lo_usage0", 64'(bus.usage_o), 64'h2);
        chk("lo_itype0", 64'(bus.itype_o), 64'h0);
        chk("lo_iretire0", 64'(bus.iretire_o), 64'h3);
        chk("lo_ilast0", 64'(bus.ilastsize_o), 64'h1);
        chk("lo_priv0", 64'(bus.priv_o), 64'h3);
        chk("lo_cause0", 64'(bus.cause_o), 64'h0);
        chk("lo_tval0", 64'(bus.tval_o), 64'h0);
        step();
        chk("lo_valid1", 64'(bus.valid_o), 64'h1);
        chk("lo_iaddr1", 64'(bus.iaddr_o), 64'h140);
        chk("lo_itype1", 64'(bus.itype_o), 64'h3);
        chk("lo_iretire1", 64'(bus.iretire_o), 64'h5);
        chk("lo_ilast1", 64'(bus.ilastsize_o), 64'h0);
        chk("lo_usage1", 64'(bus.usage_o), 64'h1);
        step();
        chk("lo_valid2", 64'(bus.valid_o), 64'h0);
        chk("lo_iaddr2", 64'(bus.iaddr_o), 64'h0);
        chk("lo_usage2", 64'(bus.usage_o), 64'h0);

        // Exception fields only on lane 0
        set_grp(2'b11, 32'h180, 32'h1C0, 4'd1, 4'd3, 5'd2, 32'hDEAD);
        step();
        idle();
        chk("ex_cause0", 64'(bus.cause_o), 64'h2);
        chk("ex_tval0", 64'(bus.tval_o), 64'hDEAD);
        step();
        chk("ex_cause1", 64'(bus.cause_o), 64'h0);
        chk("ex_tval1", 64'(bus.tval_o), 64'h0);
        chk("ex_iaddr1", 64'(bus.iaddr_o), 64'h1C0);
        step();
        chk("ex_valid2", 64'(bus.valid_o), 64'h0);

        // Overflow, drain and resync
        bus.ready_i = 1'b0;
        for (int g = 0; g < 4; g++) begin
            set_grp(2'b11, 32'h1000 + 32'(g) * 32'h10, 32'h1008 + 32'(g) * 32'h10, 4'd0, 4'd0, 5'd0, 32'h0);
            step();
            chk("ov_fill_usage", 64'(bus.usage_o), 64'(2 * (g + 1)));
        end
        chk("ov_full_ovf", 64'(bus.overflow_o), 64'h0);
        set_grp(2'b11, 32'h2000, 32'h2008, 4'd0, 4'd0, 5'd0, 32'h0);
        step();
        chk("ov_drop_usage", 64'(bus.usage_o), 64'h8);
        chk("ov_flag", 64'(bus.overflow_o), 64'h1);
        chk("ov_hold_iaddr", 64'(bus.iaddr_o), 64'h1000);
        bus.ready_i = 1'b1;
        set_grp(2'b11, 32'h3000, 32'h3008, 4'd0, 4'd0, 5'd0, 32'h0);
        for (int j = 1; j <= 8; j++) begin
            step();
            chk("dr_usage", 64'(bus.usage_o), 64'(8 - j));
            if (j < 8) begin
                exp_a = 32'h1000 + 32'(j / 2) * 32'h10 + 32'(j % 2) * 32'h8;
                chk("dr_iaddr", 64'(bus.iaddr_o), 64'(exp_a));
            end else begin
                chk("dr_empty", 64'(bus.valid_o), 64'h0);
            end
        end
        step();
        chk("dr_zero_edge_drop", 64'(bus.usage_o), 64'h0);
`ifdef TE_SERIALIZER_DROP_CNT_EN
        chk("dr_dropped", 64'(bus.dropped_o), 64'd20);
`endif
        idle();
        step();
        chk("rs_idle_valid", 64'(bus.valid_o), 64'h0);
        set_grp(2'b11, 32'h200, 32'h240, 4'd0, 4'd0, 5'd0, 32'h0);
        step();
        idle();
        chk("rs_iaddr0", 64'(bus.iaddr_o), 64'h200);
        chk("rs_tag0", 64'(bus.resync_o), 64'h1);
        chk("rs_usage0", 64'(bus.usage_o), 64'h2);
        step();
        chk("rs_iaddr1", 64'(bus.iaddr_o), 64'h240);
        chk("rs_tag1", 64'(bus.resync_o), 64'h0);
        chk("rs_ovf_sticky", 64'(bus.overflow_o), 64'h1);
        step();
        chk("rs_valid2", 64'(bus.valid_o), 64'h0);

        // Space check ignores same-cycle pop
        bus.ready_i = 1'b0;
        for (int g = 0; g < 3; g++) begin
            set_grp(2'b11, 32'h4000, 32'h4008, 4'd0, 4'd0, 5'd0, 32'h0);
            step();
        end
        set_grp(2'b01, 32'h4100, 32'h0, 4'd0, 4'd0, 5'd0, 32'h0);
        step();
        chk("sp_usage7", 64'(bus.usage_o), 64'h7);
        bus.ready_i = 1'b1;
        set_grp(2'b11, 32'h4200, 32'h4208, 4'd0, 4'd0, 5'd0, 32'h0);
        step();
        chk("sp_usage6", 64'(bus.usage_o), 64'h6);
        set_grp(2'b01, 32'h4300, 32'h0, 4'd0, 4'd0, 5'd0, 32'h0);
        step();
        chk("sp_drain_drop", 64'(bus.usage_o), 64'h5);
        bus.ready_i = 1'b0;
        idle();
`ifdef TE_SERIALIZER_DROP_CNT_EN
        chk("sp_dropped", 64'(bus.dropped_o), 64'd23);
        set_grp(2'b11, 32'h5000, 32'h5008, 4'd0, 4'd0, 5'd0, 32'h0);
        for (int i = 0; i < 32760; i++) begin
            step();
        end
        idle();
        chk("sat_dropped", 64'(bus.dropped_o), 64'hFFFF);
        step();
        chk("sat_hold", 64'(bus.dropped_o), 64'hFFFF);
        chk("sat_usage", 64'(bus.usage_o), 64'h5);
`endif

        // Reset mid-operation
        step();
        chk("mr_pre_usage", 64'(bus.usage_o), 64'h5);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mr_valid", 64'(bus.valid_o), 64'h0);
        chk("mr_usage", 64'(bus.usage_o), 64'h0);
        chk("mr_overflow", 64'(bus.overflow_o), 64'h0);
        chk("mr_iaddr", 64'(bus.iaddr_o), 64'h0);
        chk("mr_itype", 64'(bus.itype_o), 64'h0);
        chk("mr_priv", 64'(bus.priv_o), 64'h0);
`ifdef TE_SERIALIZER_DROP_CNT_EN
        chk("mr_dropped", 64'(bus.dropped_o), 64'h0);
`endif
        bus.ready_i = 1'b1;
        set_grp(2'b11, 32'h500, 32'h540, 4'd0, 4'd0, 5'd0, 32'h0);
        step();
        idle();
        chk("mr_run_iaddr", 64'(bus.iaddr_o), 64'h500);
        chk("mr_run_resync", 64'(bus.resync_o), 64'h0);
        chk("mr_run_usage", 64'(bus.usage_o), 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
